uart_bus_tx: RTL

UART_BUS_TX -- requirements
Module: uart_bus_tx

---
 rtl/uart_bus_tx.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_bus_tx.sv
// uart_bus_tx: bus-attached 8N1 UART transmitter.
// A write in IDLE latches one byte, which is then sent as a start bit, eight
// data bits (LSB first) and a stop bit. Each bit lasts CLKS_PER_BIT clocks.
// The status word reports the last byte written and a busy flag.
module uart_bus_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_wen,
  input  logic [31:0] uart_wdata,
  output logic [31:0] uart_rdata,
  output logic        uart_ready,
  output logic        uart_txd
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  // The counter only needs to reach CLKS_PER_BIT-1, so clog2 bits are enough
  // even when CLKS_PER_BIT is an exact power of two.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    last_byte_q, last_byte_d;
  logic          txd_q, txd_d;
  logic          baud_done;
  logic          busy;

  // Only the low byte of a write is transmitted; the rest is dropped.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^uart_wdata[31:8];

  assign baud_done = (baud_cnt_q == BAUD_LAST);
  assign busy      = (state_q != IDLE);

  // Next-state, counter and line-level computation.
  // The line level is derived from the current registered state, so the
  // start bit appears one cycle after the accepting edge and every bit period
  // is shifted by the same single cycle.
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    last_byte_d = last_byte_q;
    txd_d       = 1'b1;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (uart_wen) begin
          shift_d     = uart_wdata[7:0];
          last_byte_d = uart_wdata[7:0];
          baud_cnt_d  = '0;
          bit_cnt_d   = 3'd0;
          state_d     = START;
        end
      end
      START: begin
        txd_d = 1'b0;
        if (baud_done) begin
          baud_cnt_d = '0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end
      DATA: begin
        txd_d = shift_q[0];
        if (baud_done) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end
      STOP: begin
        txd_d = 1'b1;
        if (baud_done) begin
          baud_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any partial frame and idles the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      last_byte_q <= 8'h00;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      last_byte_q <= last_byte_d;
      txd_q       <= txd_d;
    end
  end

  assign uart_ready = (state_q == IDLE);
  assign uart_txd   = txd_q;
  assign uart_rdata = {16'h0000, last_byte_q, 7'h00, busy};

`ifndef SYNTHESIS
  // A bit period shorter than two clocks cannot be timed by this counter.
  always_ff @(posedge clk) begin
    assert (CLKS_PER_BIT >= 2)
      else $error("uart_bus_tx: CLKS_PER_BIT must be at least 2");
  end
`endif

endmodule
